// File: rtl/conv_1_weight_feeder_pkg.sv
// Shared constants for the conv_1 weight feeder: BRAM word geometry and the
// channel-counter width.
package conv_1_weight_feeder_pkg;
  localparam int DWIDTH = 64;
  localparam int LANE_W = 16;
  localparam int LANES  = 4;
  localparam int CH_W   = 11;

  localparam logic [CH_W-1:0] CH_STEP = CH_W'(LANES);
endpackage

// File: rtl/conv_1_weight_feeder_if.sv
// Weight stream from the feeder to the MAC array: valid/ready handshake with a
// group-last tag.
interface conv_1_weight_feeder_if #(
  parameter int DWIDTH = conv_1_weight_feeder_pkg::DWIDTH
);
  logic              w_valid;
  logic              w_ready;
  logic [DWIDTH-1:0] w_data;
  logic              w_last;

  modport master (output w_valid, w_data, w_last, input w_ready);
  modport slave  (input w_valid, w_data, w_last, output w_ready);
endinterface

// File: rtl/conv_1_weight_fifo.sv
// First-word-fall-through buffer; each entry holds one weight word plus its
// group-last tag.
module conv_1_weight_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last,
  output logic [CW-1:0]    count
);
  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Guards keep the pointers sane even if a caller misbehaves.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = push_ok ? bump(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? bump(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign head_last  = mem_q[rd_ptr_q][WIDTH];
  assign count      = count_q;
endmodule

// File: rtl/conv_1_weight_feeder.sv
// Reads weight words from the BRAM under a credit scheme (buffered + in-flight
// never exceeds FIFO_DEPTH) and streams them to the MAC array tagged with group-last.
module conv_1_weight_feeder #(
  parameter int DWIDTH     = conv_1_weight_feeder_pkg::DWIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    bram_full,
  output logic                                    conv_1_bram_valid,
  input  logic [DWIDTH-1:0]                       bram_dout,
  input  logic [conv_1_weight_feeder_pkg::CH_W-1:0] ifm_channel,
  conv_1_weight_feeder_if.master                  w
);
  import conv_1_weight_feeder_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]   occ;
  logic [CW:0]     pending;
  logic            pop;
  logic            in_flight_q, in_flight_d;
  logic [CH_W-1:0] word_cnt_q, word_cnt_d;
  logic [CH_W-1:0] last_chan;
  logic            cap_last;

  // Counting the same-cycle pop as a freed slot sustains one word per cycle.
  always_comb begin
    pop               = w.w_valid && w.w_ready;
    pending           = {1'b0, occ} + (CW+1)'(in_flight_q) - (CW+1)'(pop);
    conv_1_bram_valid = !rst && bram_full && (pending < (CW+1)'(FIFO_DEPTH));
    in_flight_d       = conv_1_bram_valid;
  end

  always_comb begin
    last_chan  = ifm_channel - CH_STEP;
    cap_last   = (word_cnt_q == last_chan);
    word_cnt_d = word_cnt_q;
    if (in_flight_q) word_cnt_d = cap_last ? '0 : word_cnt_q + CH_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  conv_1_weight_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (in_flight_q),
    .push_data  (bram_dout),
    .push_last  (cap_last),
    .pop        (pop),
    .head_valid (w.w_valid),
    .head_data  (w.w_data),
    .head_last  (w.w_last),
    .count      (occ)
  );
endmodule

// File: tb/tb_conv_1_weight_feeder.sv
// Directed bench for conv_1_weight_feeder: BRAM model, pop recorder, one task per scenario.
module tb_conv_1_weight_feeder;
  import conv_1_weight_feeder_pkg::*;

  localparam int DEPTH = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              bram_full;
  logic              conv_1_bram_valid;
  logic [DWIDTH-1:0] bram_dout;
  logic [CH_W-1:0]   ifm_channel;

  conv_1_weight_feeder_if #(.DWIDTH(DWIDTH)) wif();

  conv_1_weight_feeder #(.DWIDTH(DWIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .bram_full         (bram_full),
    .conv_1_bram_valid (conv_1_bram_valid),
    .bram_dout         (bram_dout),
    .ifm_channel       (ifm_channel),
    .w                 (wif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_idx;
  int issue_cnt;
  logic [DWIDTH:0] got_q[$];

  // Word idx of the BRAM stream: lane k = {group[4:0], channel c+k}; top bit = last tag.
  function automatic logic [DWIDTH:0] mk(input int idx, input int ifm);
    int gpw, grp, ch;
    logic [DWIDTH:0] r;
    gpw = ifm / 4;
    grp = idx / gpw;
    ch  = (idx % gpw) * 4;
    r   = '0;
    r[DWIDTH] = (ch == ifm - 4);
    for (int k = 0; k < 4; k++) r[16*k +: 16] = {5'(grp), 11'(ch + k)};
    return r;
  endfunction

  logic [DWIDTH:0] mtmp;
  always @(posedge clk) begin
    if (rst) rd_idx <= 0;
    else if (conv_1_bram_valid && bram_full) begin
      mtmp = mk(rd_idx, int'(ifm_channel));
      bram_dout <= mtmp[DWIDTH-1:0];
      rd_idx <= rd_idx + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      got_q.delete();
      issue_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wif.w_valid && wif.w_ready) got_q.push_back({wif.w_last, wif.w_data});
      if (conv_1_bram_valid && bram_full) issue_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc_drive(); @(posedge clk); #1; endtask
  task automatic cyc_look();  @(negedge clk); #1; endtask

  task automatic do_reset(input int ifm);
    rst = 1'b1; bram_full = 1'b0; wif.w_ready = 1'b0; ifm_channel = CH_W'(ifm);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    bram_full = 1'b0; wif.w_ready = 1'b1;
    repeat (DEPTH + 4) cyc_drive();
  endtask

  task automatic test_reset();
    rst = 1'b1; bram_full = 1'b1; wif.w_ready = 1'b1; ifm_channel = 11'd16;
    repeat (3) @(posedge clk);
    cyc_look();
    checks++; if (wif.w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid got %b exp 0", wif.w_valid); end
    checks++; if (conv_1_bram_valid !== 1'b0) begin errors++; $display("FAIL rst_bram_valid got %b exp 0", conv_1_bram_valid); end
    checks++; if (dut.occ !== '0) begin errors++; $display("FAIL rst_occ got %0d exp 0", dut.occ); end
    checks++; if (dut.in_flight_q !== 1'b0) begin errors++; $display("FAIL rst_in_flight got %b exp 0", dut.in_flight_q); end
    checks++; if (dut.word_cnt_q !== '0) begin errors++; $display("FAIL rst_word_cnt got %0d exp 0", dut.word_cnt_q); end
  endtask

  task automatic test_stream();
    do_reset(16);
    bram_full = 1'b1; wif.w_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc_look();
      checks++; if (conv_1_bram_valid !== 1'b1) begin errors++; $display("FAIL stream_issue cyc %0d got %b exp 1", i, conv_1_bram_valid); end
      checks++; if (wif.w_valid !== (i >= 2)) begin errors++; $display("FAIL stream_w_valid cyc %0d got %b exp %b", i, wif.w_valid, (i >= 2)); end
      cyc_drive();
    end
    drain();
    checks++; if (issue_cnt != 20) begin errors++; $display("FAIL stream_issues got %0d exp 20", issue_cnt); end
    checks++; if (got_q.size() != issue_cnt) begin errors++; $display("FAIL stream_count got %0d exp %0d", got_q.size(), issue_cnt); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i] !== mk(i, 16)) begin errors++; $display("FAIL stream_word %0d got %h exp %h", i, got_q[i], mk(i, 16)); end
    end
  endtask

  task automatic test_backpressure();
    int t;
    logic [DWIDTH:0] held;
    do_reset(8);
    bram_full = 1'b1; wif.w_ready = 1'b0;
    for (t = 0; t < 10; t++) begin
      cyc_look();
      if (wif.w_valid) break;
      cyc_drive();
    end
    checks++; if (t != 2) begin errors++; $display("FAIL bp_latency got %0d exp 2", t); end
    held = {wif.w_last, wif.w_data};
    checks++; if (held !== mk(0, 8)) begin errors++; $display("FAIL bp_first got %h exp %h", held, mk(0, 8)); end
    for (int i = 0; i < 10; i++) begin
      cyc_drive();
      cyc_look();
      checks++; if ({wif.w_last, wif.w_data} !== held) begin errors++; $display("FAIL bp_stable cyc %0d got %h exp %h", i, {wif.w_last, wif.w_data}, held); end
      checks++; if (conv_1_bram_valid !== 1'b0) begin errors++; $display("FAIL bp_no_credit cyc %0d got %b exp 0", i, conv_1_bram_valid); end
    end
    checks++; if (issue_cnt != DEPTH) begin errors++; $display("FAIL bp_issues got %0d exp %0d", issue_cnt, DEPTH); end
    cyc_drive();
    wif.w_ready = 1'b1;
    repeat (12) cyc_drive();
    drain();
    checks++; if (got_q.size() != issue_cnt || issue_cnt <= DEPTH) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_q.size(), issue_cnt); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i] !== mk(i, 8)) begin errors++; $display("FAIL bp_word %0d got %h exp %h", i, got_q[i], mk(i, 8)); end
    end
  endtask

  task automatic test_single_group();
    do_reset(4);
    bram_full = 1'b1; wif.w_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc_look();
      checks++; if (dut.word_cnt_q !== '0) begin errors++; $display("FAIL g4_word_cnt cyc %0d got %0d exp 0", i, dut.word_cnt_q); end
      cyc_drive();
    end
    drain();
    checks++; if (got_q.size() != issue_cnt || issue_cnt < 10) begin errors++; $display("FAIL g4_count got %0d exp %0d", got_q.size(), issue_cnt); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i][DWIDTH] !== 1'b1) begin errors++; $display("FAIL g4_last %0d got %b exp 1", i, got_q[i][DWIDTH]); end
      checks++; if (got_q[i] !== mk(i, 4)) begin errors++; $display("FAIL g4_word %0d got %h exp %h", i, got_q[i], mk(i, 4)); end
    end
  endtask

  task automatic test_full_drop();
    do_reset(16);
    bram_full = 1'b1; wif.w_ready = 1'b1;
    cyc_look();
    checks++; if (conv_1_bram_valid !== 1'b1) begin errors++; $display("FAIL drop_issue got %b exp 1", conv_1_bram_valid); end
    cyc_drive();
    bram_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc_look();
      checks++; if (conv_1_bram_valid !== 1'b0) begin errors++; $display("FAIL drop_idle cyc %0d got %b exp 0", i, conv_1_bram_valid); end
      cyc_drive();
    end
    checks++; if (issue_cnt != 1) begin errors++; $display("FAIL drop_issues got %0d exp 1", issue_cnt); end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL drop_count got %0d exp 1", got_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== mk(0, 16)) begin errors++; $display("FAIL drop_word got %h exp %h", got_q[0], mk(0, 16)); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    do_reset(8);
    bram_full = 1'b1; wif.w_ready = 1'b0;
    repeat (3) cyc_drive();
    cyc_look();
    checks++; if (dut.occ !== 2'd2) begin errors++; $display("FAIL mid_setup_occ got %0d exp 2", dut.occ); end
    checks++; if (dut.in_flight_q !== 1'b1) begin errors++; $display("FAIL mid_setup_in_flight got %b exp 1", dut.in_flight_q); end
    rst = 1'b1;
    #1;
    checks++; if (conv_1_bram_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_issue got %b exp 0", conv_1_bram_valid); end
    cyc_drive();
    checks++; if (wif.w_valid !== 1'b0) begin errors++; $display("FAIL mid_w_valid got %b exp 0", wif.w_valid); end
    checks++; if (dut.occ !== '0) begin errors++; $display("FAIL mid_occ got %0d exp 0", dut.occ); end
    rst = 1'b0; wif.w_ready = 1'b1;
    for (t = 0; t < 10; t++) begin
      cyc_look();
      if (wif.w_valid) break;
      cyc_drive();
    end
    checks++; if (t != 2) begin errors++; $display("FAIL mid_latency got %0d exp 2", t); end
    checks++; if ({wif.w_last, wif.w_data} !== mk(0, 8)) begin errors++; $display("FAIL mid_first got %h exp %h", {wif.w_last, wif.w_data}, mk(0, 8)); end
    drain();
  endtask

  task automatic test_random();
    int t;
    do_reset(32);
    bram_full = 1'b1;
    for (t = 0; t < 6000; t++) begin
      wif.w_ready = 1'($urandom_range(0, 1));
      bram_full = (issue_cnt < 800);
      if (got_q.size() >= 800) break;
      cyc_drive();
    end
    checks++; if (t >= 6000) begin errors++; $display("FAIL rand_timeout got %0d words exp 800", got_q.size()); end
    drain();
    checks++; if (issue_cnt != 800) begin errors++; $display("FAIL rand_issues got %0d exp 800", issue_cnt); end
    checks++; if (got_q.size() != 800) begin errors++; $display("FAIL rand_count got %0d exp 800", got_q.size()); end
    foreach (got_q[i]) begin
      checks++; if (got_q[i] !== mk(i, 32)) begin errors++; $display("FAIL rand_word %0d got %h exp %h", i, got_q[i], mk(i, 32)); end
    end
  endtask

  initial begin
    rst = 1'b1; bram_full = 1'b0; wif.w_ready = 1'b0; ifm_channel = 11'd16;
    test_reset();
    test_stream();
    test_backpressure();
    test_single_group();
    test_full_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
